// File: rtl/formatter.sv
// formatter: fetches a channel id from the arbiter, waits for a downstream grant,
// then streams the packet's words with start/end framing and one cycle of latency.
module formatter (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        a2f_val_i,
    input  logic [1:0]  a2f_id_i,
    input  logic [31:0] a2f_data_i,
    input  logic [2:0]  a2f_pkglen_sel_i,
    output logic        f2a_id_req_o,
    output logic        f2a_ack_o,
    input  logic        fmt_grant_i,
    output logic        fmt_req_o,
    output logic        fmt_val_o,
    output logic        fmt_start_o,
    output logic        fmt_end_o,
    output logic [1:0]  fmt_chid_o,
    output logic [5:0]  fmt_length_o,
    output logic [31:0] fmt_data_o
);
    typedef enum logic [2:0] {IDLE, REQ_ID, WAIT_ID, FMT_REQ, SEND} state_t;

    state_t      state, state_nxt;
    logic [5:0]  cnt, len_dec;
    logic        last, latch;

    always_comb begin
        len_dec      = (a2f_pkglen_sel_i > 3'd3) ? 6'd32 : (6'd4 << a2f_pkglen_sel_i[1:0]);
        last         = cnt == fmt_length_o - 6'd1;
        latch        = (state == WAIT_ID) && (a2f_id_i != 2'b11);
        f2a_id_req_o = state == REQ_ID;
        fmt_req_o    = state == FMT_REQ;
        f2a_ack_o    = (state == SEND) && a2f_val_i;
        state_nxt    = state;
        case (state)
            IDLE:    state_nxt = REQ_ID;
            REQ_ID:  state_nxt = WAIT_ID;
            WAIT_ID: state_nxt = latch ? FMT_REQ : IDLE;
            FMT_REQ: state_nxt = fmt_grant_i ? SEND : FMT_REQ;
            SEND:    state_nxt = (f2a_ack_o && last) ? IDLE : SEND;
            default: state_nxt = IDLE;
        endcase
    end

    // counter returns to 0 on the last word so it never exceeds 31
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state        <= IDLE;
            cnt          <= 6'd0;
            fmt_chid_o   <= 2'd0;
            fmt_length_o <= 6'd0;
            fmt_data_o   <= 32'd0;
            fmt_val_o    <= 1'b0;
            fmt_start_o  <= 1'b0;
            fmt_end_o    <= 1'b0;
        end else begin
            state       <= state_nxt;
            fmt_val_o   <= f2a_ack_o;
            fmt_start_o <= f2a_ack_o && (cnt == 6'd0);
            fmt_end_o   <= f2a_ack_o && last;
            if (f2a_ack_o) begin
                fmt_data_o <= a2f_data_i;
                cnt        <= last ? 6'd0 : cnt + 6'd1;
            end
            if (latch) begin
                fmt_chid_o   <= a2f_id_i;
                fmt_length_o <= len_dec;
                cnt          <= 6'd0;
            end
        end
    end
endmodule

// File: doc/formatter.md
FORMATTER -- requirements
Module: formatter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk_i clocks everything, and rstn_i low forces the reset state at once.
REQ-002 Ports, one per line (name  direction  width  meaning):
- clk_i  in  1  clock
- rstn_i  in  1  async active-low reset
- a2f_val_i  in  1  arbiter data valid for selected slave
- a2f_id_i  in  2  arbiter-selected channel; 2'b11 = no channel
- a2f_data_i  in  32  arbiter data word
- a2f_pkglen_sel_i  in  3  packet length code of selected slave
- f2a_id_req_o  out  1  one-cycle request for the arbiter to re-arbitrate
- f2a_ack_o  out  1  word accepted from arbiter
- fmt_grant_i  in  1  downstream grant for pending packet
- fmt_req_o  out  1  packet ready, awaiting grant
- fmt_val_o  out  1  fmt_data_o valid this cycle
- fmt_start_o  out  1  first word of packet
- fmt_end_o  out  1  last word of packet
- fmt_chid_o  out  2  channel id of current packet
- fmt_length_o  out  6  packet length in words
- fmt_data_o  out  32  packet data word

Function
REQ-003 FSM states: IDLE, REQ_ID, WAIT_ID, FMT_REQ, SEND; one-hot or binary encoding is allowed.
REQ-004 IDLE SHALL move to REQ_ID unconditionally on the next clock.
REQ-005 f2a_id_req_o SHALL be 1 only in REQ_ID, which lasts exactly one cycle, then moves to WAIT_ID.
REQ-006 In WAIT_ID, a2f_id_i == 2'b11:
- next state IDLE
- no outputs change
- retry interval is 3 cycles (IDLE, REQ_ID, WAIT_ID).
REQ-007 In WAIT_ID, a2f_id_i != 2'b11:
- latch fmt_chid_o <= a2f_id_i
- latch fmt_length_o <= decoded length
- clear word counter
- next state FMT_REQ
REQ-008 Length decode of a2f_pkglen_sel_i:
- 0 -> 4, 1 -> 8, 2 -> 16, 3 -> 32
- 4..7 -> 32 (saturate)
REQ-009 fmt_req_o SHALL be 1 only in FMT_REQ.
- fmt_grant_i high in FMT_REQ -> SEND next cycle.
- fmt_grant_i SHALL be ignored in all other states.
REQ-010 In SEND, f2a_ack_o SHALL equal a2f_val_i (combinational); it is 0 in every other state.
REQ-011 On each clock edge with f2a_ack_o = 1:
- fmt_data_o <= a2f_data_i
- fmt_val_o <= 1 (one cycle)
- fmt_start_o <= (counter == 0)
- fmt_end_o <= (counter == fmt_length_o-1)
- counter increments
- result: one-cycle output latency from accept to fmt_* word.
REQ-012 Edges without an accept SHALL drive fmt_val_o, fmt_start_o and fmt_end_o to 0 and hold fmt_data_o; gaps in a2f_val_i stall the packet without losing or duplicating words.
REQ-013 Accepting the last word (counter == length-1) SHALL move SEND to IDLE, so f2a_ack_o is never asserted for a word beyond the packet length.
REQ-014 fmt_chid_o and fmt_length_o SHALL hold their values until the next successful WAIT_ID latch.
REQ-015 The counter SHALL be 6 bits wide and SHALL never wrap within a packet; the maximum value reached is 31.
REQ-016 A 4-word packet SHALL allow fmt_end_o and f2a_id_req_o activity of the following cycle sequence to overlap with no interaction.

Reset
REQ-017 When rstn_i is low, the block SHALL be in state IDLE with the counter at 0 and these outputs at 0:
- f2a_id_req_o, f2a_ack_o
- fmt_req_o, fmt_val_o, fmt_start_o, fmt_end_o
- fmt_chid_o, fmt_length_o, fmt_data_o
REQ-018 Reset asserted mid-packet SHALL abandon the packet without emitting fmt_end_o.
- After release, the first f2a_id_req_o pulse SHALL appear in the second cycle.

Verification
REQ-019 Reset release with a2f_id_i = 11 held -> f2a_id_req_o pulses every 3rd cycle; fmt_req_o stays 0.
REQ-020 Stimulus:
- a2f_id_i = 01, sel = 0, grant given 2 cycles after fmt_req_o
- a2f_val_i held 1, data 0xA0..0xA3
Required response:
- fmt_chid_o = 1, fmt_length_o = 4
- 4 consecutive fmt_val_o with data 0xA0..0xA3
- fmt_start_o on the first word, fmt_end_o on the fourth
REQ-021 Stimulus: sel = 3, a2f_val_i toggling 1/0. Required response:
- exactly 32 acks and 32 fmt_val_o beats
- fmt_end_o on the 32nd beat
- no ack after the 32nd beat
REQ-022 Stimulus: sel = 6. Required response: fmt_length_o = 32.
REQ-023 Stimulus: grant withheld 20 cycles. Required response:
- fmt_req_o held high
- f2a_ack_o = 0 throughout
- fmt_grant_i pulses in IDLE/SEND have no effect
REQ-024 Stimulus: rstn_i low after the 3rd word of an 8-word packet. Required response:
- all outputs 0 immediately
- no fmt_end_o
- clean 4-word packet on channel 2 afterwards
